// File: rtl/dmem_sram_bridge_pkg.sv
// Shared state encodings and bus size codes for the M-stage data-memory bridge.
package dmem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/dmem_sram_bridge.sv
// Runs one M-stage load/store on the SRAM-like data bus, stalls the pipeline
// until it completes and holds the read data while M is frozen elsewhere.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_en,
  input  logic [DATA_W/8-1:0]   mem_wen,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_exc,
  input  logic                  flush,
  input  logic                  stall_other,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_stall
);

  state_t                state;
  logic                  discard;
  logic [DATA_W-1:0]     hold_q;

  logic [DATA_W/8-1:0]   req_wen;
  logic [1:0]            req_size;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  go;
  logic                  to_hold;
  logic [DATA_W/8-1:0]   wen_sel;

  assign go      = mem_en & ~mem_exc & ~flush;
  // A flush arriving with data_ok kills the instruction, so it must not park in HOLD.
  assign to_hold = data_data_ok & ~discard & stall_other & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      discard <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) state <= data_addr_ok ? S_WAIT : S_REQ;
        end
        S_REQ: begin
          if (flush)        discard <= 1'b1;
          if (data_addr_ok) state   <= S_WAIT;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            discard <= 1'b0;
            if (to_hold) begin
              hold_q <= data_rdata;
              state  <= S_HOLD;
            end else begin
              state  <= S_IDLE;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall_other || flush) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request fields track the M stage while idle and freeze once the bus owns them.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      req_wen   <= mem_wen;
      req_size  <= mem_size;
      req_addr  <= mem_addr;
      req_wdata <= mem_wdata;
    end
  end

  always_comb begin
    wen_sel    = mem_wen;
    data_size  = mem_size;
    data_addr  = mem_addr;
    data_wdata = mem_wdata;
    if (state != S_IDLE) begin
      wen_sel    = req_wen;
      data_size  = req_size;
      data_addr  = req_addr;
      data_wdata = req_wdata;
    end
    data_wstrb = wen_sel;
    data_wr    = |wen_sel;
  end

  always_comb begin
    data_req  = 1'b0;
    mem_stall = 1'b0;
    mem_rdata = hold_q;
    case (state)
      S_IDLE: begin
        data_req  = go;
        mem_stall = go;
      end
      S_REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
      end
      S_WAIT: begin
        mem_stall = ~(data_data_ok & ~discard);
        if (data_data_ok && !discard) mem_rdata = data_rdata;
      end
      S_HOLD: begin
        mem_rdata = hold_q;
      end
      default: begin
        data_req  = 1'b0;
        mem_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: hand-computed expectations, bus slave driven per cycle.
module tb_dmem_sram_bridge;
  import dmem_sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_exc;
  logic        flush;
  logic        stall_other;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned hs   = 0;
  int unsigned hs0;

  dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_exc(mem_exc), .flush(flush), .stall_other(stall_other),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  // Accepted bus transactions, counted from the handshake itself.
  always @(posedge clk)
    if (resetn && data_req && data_addr_ok) hs <= hs + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_en = 0; mem_wen = '0; mem_size = SIZE_W; mem_addr = '0; mem_wdata = '0;
    mem_exc = 0; flush = 0; stall_other = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    repeat (2) next_cycle();
    resetn = 1;
    @(negedge clk);
    check("rst_req",   {31'd0, data_req},  32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_rdata", mem_rdata,          32'd0);
    next_cycle();

    // word load, addr_ok immediately, data_ok next cycle
    hs0 = hs;
    mem_en = 1; mem_size = SIZE_W; mem_addr = 32'h1000; data_addr_ok = 1;
    @(negedge clk);
    check("ld_req",   {31'd0, data_req},  32'd1);
    check("ld_stall", {31'd0, mem_stall}, 32'd1);
    check("ld_wr",    {31'd0, data_wr},   32'd0);
    check("ld_addr",  data_addr,          32'h1000);
    next_cycle();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("ld_req2",   {31'd0, data_req},  32'd0);
    check("ld_stall2", {31'd0, mem_stall}, 32'd0);
    check("ld_rdata",  mem_rdata,          32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("ld_hs", hs - hs0, 32'd1);
    next_cycle();

    // byte store, addr_ok after 3 wait cycles; M-stage inputs scrambled once latched
    hs0 = hs;
    mem_en = 1; mem_wen = 4'b1000; mem_size = SIZE_B; mem_addr = 32'h1003;
    mem_wdata = 32'h5A5A5A5A;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) data_addr_ok = 1;
      @(negedge clk);
      check("sb_req",   {31'd0, data_req},   32'd1);
      check("sb_wr",    {31'd0, data_wr},    32'd1);
      check("sb_size",  {30'd0, data_size},  {30'd0, SIZE_B});
      check("sb_addr",  data_addr,           32'h1003);
      check("sb_wstrb", {28'd0, data_wstrb}, 32'h8);
      check("sb_wdata", data_wdata,          32'h5A5A5A5A);
      check("sb_stall", {31'd0, mem_stall},  32'd1);
      next_cycle();
      mem_wen = 4'b0011; mem_size = SIZE_H; mem_addr = 32'hFFFF_FFF0; mem_wdata = '0;
    end
    data_addr_ok = 0; data_data_ok = 1;
    @(negedge clk);
    check("sb_req_w",   {31'd0, data_req},  32'd0);
    check("sb_release", {31'd0, mem_stall}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("sb_hs", hs - hs0, 32'd1);
    next_cycle();

    // load completes under stall_other, held for two more frozen cycles
    hs0 = hs;
    mem_en = 1; mem_addr = 32'h2000; data_addr_ok = 1;
    next_cycle();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h12345678; stall_other = 1;
    @(negedge clk);
    check("hold_stall0", {31'd0, mem_stall}, 32'd0);
    check("hold_rdata0", mem_rdata,          32'h12345678);
    next_cycle();
    data_data_ok = 0; data_rdata = 32'h0BAD0BAD;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) stall_other = 0;
      @(negedge clk);
      check("hold_rdata", mem_rdata,          32'h12345678);
      check("hold_req",   {31'd0, data_req},  32'd0);
      check("hold_stall", {31'd0, mem_stall}, 32'd0);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("hold_idle_req", {31'd0, data_req}, 32'd0);
    check("hold_hs", hs - hs0, 32'd1);
    next_cycle();

    // access with exception never reaches the bus
    hs0 = hs;
    mem_en = 1; mem_exc = 1; mem_addr = 32'h1001; data_addr_ok = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("exc_req",   {31'd0, data_req},  32'd0);
      check("exc_stall", {31'd0, mem_stall}, 32'd0);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("exc_hs", hs - hs0, 32'd0);
    next_cycle();

    // flush while waiting: data_ok swallowed with stall held, next access issues after
    hs0 = hs;
    mem_en = 1; mem_addr = 32'h3000; data_addr_ok = 1;
    next_cycle();
    mem_en = 0; data_addr_ok = 0; flush = 1;
    @(negedge clk);
    check("fl_stall_w", {31'd0, mem_stall}, 32'd1);
    next_cycle();
    flush = 0; data_data_ok = 1; data_rdata = 32'hAAAA5555;
    mem_en = 1; mem_addr = 32'h4000;
    @(negedge clk);
    check("fl_stall_ok", {31'd0, mem_stall}, 32'd1);
    check("fl_req_ok",   {31'd0, data_req},  32'd0);
    check("fl_hs",       hs - hs0,           32'd1);
    next_cycle();
    data_data_ok = 0; data_rdata = '0;
    @(negedge clk);
    check("fl_next_req",  {31'd0, data_req}, 32'd1);
    check("fl_next_addr", data_addr,         32'h4000);
    next_cycle();

    // reset asserted while in REQ
    mem_en = 0; resetn = 0;
    @(negedge clk);
    check("rq_req",  {31'd0, data_req}, 32'd1);
    check("rq_addr", data_addr,         32'h4000);
    next_cycle();
    resetn = 1;
    @(negedge clk);
    check("rq_rst_req",   {31'd0, data_req},  32'd0);
    check("rq_rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rq_rst_hold",  mem_rdata,          32'd0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
